// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding, I/O window constants and
// wait-counter width.
package mem_pkg;

    localparam int unsigned CNT_W = 4;

    localparam logic [15:0] IO_BASE = 16'hFF00;
    localparam logic [15:0] IO_MASK = 16'hFF00;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess,
        StResp
    } state_t;

endpackage

// File: rtl/ram_sp.sv
// Single-port word RAM, synchronous read-first, no reset so it maps onto block RAM.
module ram_sp #(
    parameter int unsigned SIZE      = 16,
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 i_clk,
    input  logic                 i_en,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_adr,
    input  logic [SIZE-1:0]      i_wd,
    output logic [SIZE-1:0]      o_rd
);

    logic [SIZE-1:0] r_mem [2**ADDR_BITS];
    logic [SIZE-1:0] r_rd;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_adr] <= i_wd;
            end
            r_rd <= r_mem[i_adr];
        end
    end

    assign o_rd = r_rd;

endmodule

// File: rtl/mem_responder.sv
// CPU memory-port responder: one request at a time, programmable wait states, one-cycle
// ready pulse. Define MEM_IO_EN to map the 0xFFxx window onto io_in/io_out.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned SIZE        = 16,
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_req,
    input  logic            i_memwrite,
    input  logic [SIZE-1:0] i_adr,
    input  logic [SIZE-1:0] i_wd,
    output logic [SIZE-1:0] o_memdata,
    output logic            o_ready,
    output logic            o_busy,
    input  logic [SIZE-1:0] i_io_in,
    output logic [SIZE-1:0] o_io_out
);

    state_t              r_state, w_state_d;
    logic [CNT_W-1:0]    r_cnt, w_cnt_d;
    logic                w_accept;
    logic [SIZE-1:0]     r_adr, r_wd, r_memdata;
    logic                r_write;
    logic                w_io_hit;
    logic                w_ram_en, w_ram_we;
    logic [ADDR_BITS-1:0] w_ram_adr;
    logic [SIZE-1:0]     w_ram_q, w_rd_data;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_accept  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_req) begin
                    w_accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_state_d = StAccess;
                    end else begin
                        w_state_d = StWait;
                        w_cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            StWait: begin
                if (r_cnt == '0) begin
                    w_state_d = StAccess;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            StAccess: w_state_d = StResp;
            StResp:   w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_memdata <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (r_state == StAccess && !r_write) begin
                r_memdata <= w_rd_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_adr   <= i_adr;
            r_wd    <= i_wd;
            r_write <= i_memwrite;
        end
    end

    // Read is launched on the edge entering ACCESS, so with no wait states the address
    // must bypass the request latch.
    assign w_ram_adr = (r_state == StIdle) ? i_adr[ADDR_BITS-1:0] : r_adr[ADDR_BITS-1:0];
    assign w_ram_we  = (r_state == StAccess) && r_write && !w_io_hit;
    assign w_ram_en  = (w_state_d == StAccess) || w_ram_we;

    ram_sp #(
        .SIZE      (SIZE),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .i_clk (i_clk),
        .i_en  (w_ram_en),
        .i_we  (w_ram_we),
        .i_adr (w_ram_adr),
        .i_wd  (r_wd),
        .o_rd  (w_ram_q)
    );

`ifdef MEM_IO_EN
    logic            w_io_reg;
    logic [SIZE-1:0] r_io_out;

    assign w_io_hit = (r_adr & SIZE'(IO_MASK)) == SIZE'(IO_BASE);
    assign w_io_reg = r_adr == SIZE'(IO_BASE);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_io_out <= '0;
        end else if (r_state == StAccess && r_write && w_io_reg) begin
            r_io_out <= r_wd;
        end
    end

    always_comb begin
        w_rd_data = w_ram_q;
        if (w_io_hit) begin
            w_rd_data = w_io_reg ? i_io_in : '0;
        end
    end

    assign o_io_out = r_io_out;
`else
    logic w_unused_io;

    assign w_io_hit    = 1'b0;
    assign w_rd_data   = w_ram_q;
    assign o_io_out    = '0;
    assign w_unused_io = ^{i_io_in, r_adr[SIZE-1:ADDR_BITS]};
`endif

    assign o_memdata = r_memdata;
    assign o_ready   = (r_state == StResp);
    assign o_busy    = (r_state != StIdle);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with WAIT_STATES 0, 1 and 4.
// Instance index: 0 -> WS=0, 1 -> WS=1, 2 -> WS=4.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = '0;
    logic        we = 1'b0;
    logic [15:0] adr = '0;
    logic [15:0] wd = '0;
    logic [15:0] io_in = '0;
    logic [15:0] md  [3];
    logic [15:0] io  [3];
    logic        rdy [3];
    logic        bsy [3];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_responder #(.SIZE(16), .ADDR_BITS(10), .WAIT_STATES(0)) dut0 (
        .i_clk(clk), .i_reset(rst_n), .i_req(req[0]), .i_memwrite(we), .i_adr(adr),
        .i_wd(wd), .o_memdata(md[0]), .o_ready(rdy[0]), .o_busy(bsy[0]),
        .i_io_in(io_in), .o_io_out(io[0])
    );

    mem_responder #(.SIZE(16), .ADDR_BITS(10), .WAIT_STATES(1)) dut1 (
        .i_clk(clk), .i_reset(rst_n), .i_req(req[1]), .i_memwrite(we), .i_adr(adr),
        .i_wd(wd), .o_memdata(md[1]), .o_ready(rdy[1]), .o_busy(bsy[1]),
        .i_io_in(io_in), .o_io_out(io[1])
    );

    mem_responder #(.SIZE(16), .ADDR_BITS(10), .WAIT_STATES(4)) dut4 (
        .i_clk(clk), .i_reset(rst_n), .i_req(req[2]), .i_memwrite(we), .i_adr(adr),
        .i_wd(wd), .o_memdata(md[2]), .o_ready(rdy[2]), .o_busy(bsy[2]),
        .i_io_in(io_in), .o_io_out(io[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request from a negedge, then watch a fixed 12-cycle window.
    task automatic xact(input string tag, input int sel, input bit w, input logic [15:0] a,
                        input logic [15:0] d, input int exp_lat, input logic [15:0] exp_md,
                        input bit pulse_wait, output logic [15:0] io_cap);
        int          lat = 0;
        int          nb = 0;
        int          nr = 0;
        logic [15:0] md_cap = 'x;
        io_cap   = 'x;
        we       = w;
        adr      = a;
        wd       = d;
        req[sel] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) req[sel] = pulse_wait;
            if (i == 2) req[sel] = 1'b0;
            if (bsy[sel]) nb++;
            if (rdy[sel]) begin
                nr++;
                if (lat == 0) begin
                    lat    = i;
                    md_cap = md[sel];
                    io_cap = io[sel];
                end
            end
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".busy_cycles"}, 32'(nb), 32'(exp_lat));
        check({tag, ".ready_pulses"}, 32'(nr), 32'd1);
        check({tag, ".memdata"}, {16'h0, md_cap}, {16'h0, exp_md});
    endtask

    logic [15:0] io_cap;
    logic [15:0] last_md;

    initial begin
        repeat (3) @(negedge clk);
        check("rst.ready", {31'h0, rdy[1]}, 32'd0);
        check("rst.busy", {31'h0, bsy[1]}, 32'd0);
        check("rst.memdata", {16'h0, md[1]}, 32'd0);
        check("rst.io_out", {16'h0, io[1]}, 32'd0);
        check("rst.memdata_ws0", {16'h0, md[0]}, 32'd0);
        check("rst.io_out_ws4", {16'h0, io[2]}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        xact("ws1.wr5", 1, 1'b1, 16'h0005, 16'h1234, 3, 16'h0000, 1'b0, io_cap);
        xact("ws1.rd5", 1, 1'b0, 16'h0005, 16'h0000, 3, 16'h1234, 1'b0, io_cap);

        xact("ws0.wr7", 0, 1'b1, 16'h0007, 16'hAAAA, 2, 16'h0000, 1'b0, io_cap);
        xact("ws0.rd7", 0, 1'b0, 16'h0007, 16'h0000, 2, 16'hAAAA, 1'b0, io_cap);
        xact("ws4.wr7", 2, 1'b1, 16'h0007, 16'h5555, 6, 16'h0000, 1'b0, io_cap);
        xact("ws4.rd7", 2, 1'b0, 16'h0007, 16'h0000, 6, 16'h5555, 1'b0, io_cap);

        // 0x0405 aliases onto word 5; the second read also sees a req pulse during WAIT.
        xact("alias.wr405", 1, 1'b1, 16'h0405, 16'hBEEF, 3, 16'h1234, 1'b0, io_cap);
        xact("alias.rd5", 1, 1'b0, 16'h0005, 16'h0000, 3, 16'hBEEF, 1'b1, io_cap);

`ifdef MEM_IO_EN
        xact("io.wr300", 1, 1'b1, 16'h0300, 16'h3333, 3, 16'hBEEF, 1'b0, io_cap);
        xact("io.wrff00", 1, 1'b1, 16'hFF00, 16'h00A5, 3, 16'hBEEF, 1'b0, io_cap);
        check("io.io_out_resp", {16'h0, io_cap}, 32'h0000_00A5);
        io_in = 16'h5A5A;
        xact("io.rdff00", 1, 1'b0, 16'hFF00, 16'h0000, 3, 16'h5A5A, 1'b0, io_cap);
        xact("io.rdff10", 1, 1'b0, 16'hFF10, 16'h0000, 3, 16'h0000, 1'b0, io_cap);
        xact("io.rd300", 1, 1'b0, 16'h0300, 16'h0000, 3, 16'h3333, 1'b0, io_cap);
        last_md = 16'h3333;
`else
        xact("noio.wrff00", 1, 1'b1, 16'hFF00, 16'h00A5, 3, 16'hBEEF, 1'b0, io_cap);
        check("noio.io_out_resp", {16'h0, io_cap}, 32'h0000_0000);
        xact("noio.rd300", 1, 1'b0, 16'h0300, 16'h0000, 3, 16'h00A5, 1'b0, io_cap);
        last_md = 16'h00A5;
`endif

        xact("rstw.wr10", 1, 1'b1, 16'h0010, 16'h1111, 3, last_md, 1'b0, io_cap);
        // Reset lands on the WAIT->ACCESS edge, so the 0x7777 write must be dropped.
        we     = 1'b1;
        adr    = 16'h0010;
        wd     = 16'h7777;
        req[1] = 1'b1;
        @(negedge clk);
        req[1] = 1'b0;
        check("rstw.busy_in_wait", {31'h0, bsy[1]}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstw.busy", {31'h0, bsy[1]}, 32'd0);
        check("rstw.ready", {31'h0, rdy[1]}, 32'd0);
        check("rstw.memdata", {16'h0, md[1]}, 32'd0);
        check("rstw.io_out", {16'h0, io[1]}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        xact("rstw.rd10", 1, 1'b0, 16'h0010, 16'h0000, 3, 16'h1111, 1'b0, io_cap);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU datapath's memory port. It accepts one read or write request at a time on the CPU's `adr`/`wd`/`memwrite` signals, serves it from an internal single-port word RAM after a programmable number of wait states, and returns read data on `memdata` with a one-cycle `ready` pulse. It sits between the CPU core and on-chip storage, with optional memory-mapped I/O.

## Interface
- `SIZE`, 16, data and address word width in bits
- `ADDR_BITS`, 10, RAM index width; depth is 2^ADDR_BITS words
- `WAIT_STATES`, 1, extra cycles inserted before each access, 0..15
- `clk` in 1 — single clock; all state changes on the rising edge
- `reset` in 1 — synchronous, active-low reset
- `req` in 1 — request strobe; sampled only in IDLE
- `memwrite` in 1 — 1 = write, 0 = read; sampled with `req`
- `adr` in SIZE — word address; sampled with `req`
- `wd` in SIZE — write data; sampled with `req`
- `memdata` out SIZE — read data; registered, holds until the next read response
- `ready` out 1 — one-cycle pulse marking completion of a read or write
- `busy` out 1 — high in every state except IDLE
- `io_in` in SIZE — external input word, used only with `MEM_IO_EN`
- `io_out` out SIZE — external output register, used only with `MEM_IO_EN`

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- **IDLE:**
  - With `req`=1, latch `adr`, `wd` and `memwrite` into internal registers.
  - Go to WAIT with the counter loaded to WAIT_STATES−1, or go directly to ACCESS if WAIT_STATES=0.
  - With `req`=0, stay in IDLE.
- **WAIT:** count down; at 0, go to ACCESS. Changes on the CPU request inputs are ignored.
- **ACCESS:** issue a single RAM operation using the latched address bits [ADDR_BITS−1:0]; the RAM read is synchronous. Go to RESP.
  - Write: RAM word updated at the end of ACCESS.
  - Read: RAM output registered into `memdata` at the end of ACCESS.
- **RESP:** `ready`=1 for exactly this cycle; next state is IDLE.
- Requests are never queued. A `req` seen outside IDLE is dropped, and the CPU must hold or reissue it.
- Address bits at and above ADDR_BITS are ignored, so addresses alias modulo the RAM depth (except the I/O window, see Configuration).
- Writes leave `memdata` unchanged.
- Read-after-write to the same address returns the newly written value.
- RAM contents are not initialised by reset.

## Timing
- Request sampled at edge N (IDLE, `req`=1): `ready` is high in cycle N+WAIT_STATES+2, and `memdata` is valid from that cycle.
  - Default WAIT_STATES=1: `ready` is high in cycle N+3.
- Minimum spacing between accepted requests is WAIT_STATES+3 cycles. The next `req` can be accepted in the cycle after RESP.
- Reset (`reset`=0 at an edge), from any state:
  - State → IDLE; `ready`=0, `busy`=0, `memdata`=0, `io_out`=0.
  - An in-flight write is dropped if reset hits before the ACCESS edge, and committed if reset coincides with or follows it.
- `req` held high continuously: a new request is accepted on every return to IDLE.

## Configuration
- `MEM_IO_EN` defined: an address whose upper byte is all ones (0xFFxx for SIZE=16) selects the I/O window instead of RAM.
  - Write to 0xFF00 loads `io_out` at the end of ACCESS.
  - Read of 0xFF00 returns `io_in`, sampled during ACCESS.
  - Other 0xFFxx addresses: reads return 0, writes are ignored.
  - Access timing is identical to RAM accesses.
- `MEM_IO_EN` undefined: no window; all addresses alias into RAM, `io_out` is tied to 0 and `io_in` is unused.

## Structure
- Shared package `mem_pkg` holds:
  - FSM state encoding (2 bits);
  - I/O window base 0xFF00 and mask 0xFF00;
  - wait-counter width (4 bits).
- One sub-module, `ram_sp`: parameterised SIZE × 2^ADDR_BITS single-port RAM with synchronous read and write-enable. It contains no reset logic and must infer block RAM.
- FSM, counter, request latches and I/O register live in `mem_responder`.

## Test plan
- Reset, then write 0x1234 to 0x0005 and read 0x0005 → one `ready` pulse per access; read gives `memdata`=0x1234 exactly 3 cycles after the read `req` (WAIT_STATES=1).
- WAIT_STATES=0 vs 4 → `ready` appears 2 vs 6 cycles after acceptance; `busy` is high for exactly those cycles.
- Write 0xBEEF to 0x0405 (ADDR_BITS=10), then read 0x0005 → 0xBEEF (aliasing). A `req` pulsed during WAIT → ignored, no extra `ready`.
- `MEM_IO_EN`:
  - write 0x00A5 to 0xFF00 → `io_out`=0x00A5 in the RESP cycle;
  - `io_in`=0x5A5A, read 0xFF00 → 0x5A5A;
  - read 0xFF10 → 0; RAM word 0x0300 unchanged.
- Reset during WAIT of a write of 0x7777 to 0x0010, then read 0x0010 → old value returned; `memdata`/`io_out` show 0 right after reset.
